// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 8;
    localparam int PERF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals between the CPU datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: memory hold is carried by MEM_Req_i/MEM_Ack_i and reflected as Freeze_o.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic                  start_i;
    logic [REG_ADDR_W-1:0] RS1addr_i;
    logic [REG_ADDR_W-1:0] RS2addr_i;
    logic                  UseRS1_i;
    logic                  UseRS2_i;
    logic                  EX_MemRead_i;
    logic [REG_ADDR_W-1:0] EX_RDaddr_i;
    logic                  Branch_i;
    logic                  MEM_Req_i;
    logic                  MEM_Ack_i;
    logic                  PCWrite_o;
    logic                  Stall_o;
    logic                  NoOp_o;
    logic                  Flush_o;
    logic                  Freeze_o;
    logic [PERF_CNT_W-1:0] StallCnt_o;
    logic [PERF_CNT_W-1:0] FlushCnt_o;
    logic                  Err_o;

    // Datapath side: drives the pipeline status, receives the control decisions.
    modport master (
        output start_i, RS1addr_i, RS2addr_i, UseRS1_i, UseRS2_i,
               EX_MemRead_i, EX_RDaddr_i, Branch_i, MEM_Req_i, MEM_Ack_i,
        input  PCWrite_o, Stall_o, NoOp_o, Flush_o, Freeze_o,
               StallCnt_o, FlushCnt_o, Err_o
    );

    // Controller side.
    modport slave (
        input  start_i, RS1addr_i, RS2addr_i, UseRS1_i, UseRS2_i,
               EX_MemRead_i, EX_RDaddr_i, Branch_i, MEM_Req_i, MEM_Ack_i,
        output PCWrite_o, Stall_o, NoOp_o, Flush_o, Freeze_o,
               StallCnt_o, FlushCnt_o, Err_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none; holds at MAX instead of wrapping.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Count up until MAX, then hold; clr returns to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze with perf counters.
// Latency: control outputs are combinational from state and inputs; counters and Err_o update 1 cycle later.
// Backpressure: an unacknowledged memory request freezes the whole pipeline until MEM_Ack_i.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_TIMEOUT);

    hazard_state_t         state;
    logic                  active;
    logic                  loaduse;
    logic                  mem_enter;
    logic                  freeze;
    logic                  pc_write;
    logic                  stall;
    logic                  noop;
    logic                  flush;
    logic                  err_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] flush_cnt;

    // Load-use hazard: EX load writes a register the ID instruction reads; x0 never hazards.
    always_comb begin
        loaduse = bus.EX_MemRead_i && (bus.EX_RDaddr_i != '0) &&
                  ((bus.UseRS1_i && (bus.EX_RDaddr_i == bus.RS1addr_i)) ||
                   (bus.UseRS2_i && (bus.EX_RDaddr_i == bus.RS2addr_i)));
    end

    // Memory hold: a pending request without ack freezes, both on the request cycle and while waiting.
    always_comb begin
        active    = (state == ST_RUN) || (state == ST_MEM_WAIT);
        mem_enter = (state == ST_RUN) && bus.MEM_Req_i && !bus.MEM_Ack_i;
        freeze    = !rst_i && (mem_enter || ((state == ST_MEM_WAIT) && !bus.MEM_Ack_i));
    end

    // Output decode, priority freeze > load-use > normal flow; reset and IDLE hold the PC.
    always_comb begin
        pc_write = 1'b0;
        stall    = 1'b1;
        noop     = 1'b0;
        flush    = 1'b0;
        if (!rst_i && active && !freeze) begin
            if (loaduse) begin
                noop = 1'b1;
            end else begin
                pc_write = 1'b1;
                stall    = 1'b0;
                flush    = bus.Branch_i;
            end
        end
    end

    // State register; start_i only matters in IDLE, an ack in the request cycle skips MEM_WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (bus.start_i) state <= ST_RUN;
                ST_RUN:      if (bus.MEM_Req_i && !bus.MEM_Ack_i) state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (bus.MEM_Ack_i) state <= ST_RUN;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Sticky timeout flag: sets on the edge where the wait counter reaches the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if ((state == ST_MEM_WAIT) && (wait_cnt >= WAIT_MAX - WAIT_CNT_W'(1))) begin
            err_q <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(WAIT_CNT_W), .MAX(WAIT_MAX)) u_wait_cnt (
        .clk (clk_i),
        .clr (rst_i || mem_enter),
        .inc (state == ST_MEM_WAIT),
        .cnt (wait_cnt)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .clr (rst_i),
        .inc (active && !pc_write),
        .cnt (stall_cnt)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk (clk_i),
        .clr (rst_i),
        .inc (flush),
        .cnt (flush_cnt)
    );

    assign bus.PCWrite_o  = pc_write;
    assign bus.Stall_o    = stall;
    assign bus.NoOp_o     = noop;
    assign bus.Flush_o    = flush;
    assign bus.Freeze_o   = freeze;
    assign bus.StallCnt_o = stall_cnt;
    assign bus.FlushCnt_o = flush_cnt;
    assign bus.Err_o      = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a reference model.
// Latency: inputs driven after the rising edge, Mealy outputs sampled on the falling edge, counters after the edge.
// Backpressure: memory waits stimulated through MEM_Req_i/MEM_Ack_i.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_WAIT  = 2;

    // Control vector order: {PCWrite, Stall, NoOp, Flush, Freeze}
    localparam logic [4:0] C_HOLD   = 5'b01000;
    localparam logic [4:0] C_FREEZE = 5'b01001;
    localparam logic [4:0] C_BUBBLE = 5'b01100;
    localparam logic [4:0] C_FLOW   = 5'b10000;
    localparam logic [4:0] C_FLUSH  = 5'b10010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_state;
    int m_wait;
    int m_stall;
    int m_flush;
    bit m_err;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] ctrl_now();
        return {bus.PCWrite_o, bus.Stall_o, bus.NoOp_o, bus.Flush_o, bus.Freeze_o};
    endfunction

    // Expected control vector from the rules: reset/IDLE hold, then freeze, load-use, normal flow.
    function automatic logic [4:0] model_ctrl();
        bit lu, fr;
        lu = bus.EX_MemRead_i && (bus.EX_RDaddr_i != 0) &&
             ((bus.UseRS1_i && bus.EX_RDaddr_i == bus.RS1addr_i) ||
              (bus.UseRS2_i && bus.EX_RDaddr_i == bus.RS2addr_i));
        fr = (m_state == M_RUN && bus.MEM_Req_i && !bus.MEM_Ack_i) ||
             (m_state == M_WAIT && !bus.MEM_Ack_i);
        if (rst || m_state == M_IDLE) return C_HOLD;
        if (fr) return C_FREEZE;
        if (lu) return C_BUBBLE;
        return {1'b1, 1'b0, 1'b0, bus.Branch_i, 1'b0};
    endfunction

    task automatic clear_inputs();
        bus.start_i      = 1'b0;
        bus.RS1addr_i    = '0;
        bus.RS2addr_i    = '0;
        bus.UseRS1_i     = 1'b0;
        bus.UseRS2_i     = 1'b0;
        bus.EX_MemRead_i = 1'b0;
        bus.EX_RDaddr_i  = '0;
        bus.Branch_i     = 1'b0;
        bus.MEM_Req_i    = 1'b0;
        bus.MEM_Ack_i    = 1'b0;
    endtask

    // Advance one clock and step the model with the inputs seen at that edge.
    task automatic tick();
        logic [4:0] o;
        @(posedge clk);
        o = model_ctrl();
        if (rst) begin
            m_state = M_IDLE; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
        end else begin
            if (m_state != M_IDLE && !o[4]) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
            if (o[1]) m_flush = (m_flush >= 65535) ? 65535 : m_flush + 1;
            case (m_state)
                M_IDLE: if (bus.start_i) m_state = M_RUN;
                M_RUN: if (bus.MEM_Req_i && !bus.MEM_Ack_i) begin
                    m_state = M_WAIT;
                    m_wait  = 0;
                end
                M_WAIT: begin
                    m_wait = (m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1;
                    if (m_wait >= TIMEOUT) m_err = 1;
                    if (bus.MEM_Ack_i) m_state = M_RUN;
                end
                default: m_state = M_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic do_reset_and_start();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        bus.EX_MemRead_i = 1'b1;
        bus.EX_RDaddr_i  = rd;
        bus.RS1addr_i    = rs1;
        bus.UseRS1_i     = u1;
        bus.RS2addr_i    = rs2;
        bus.UseRS2_i     = u2;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.start_i = 1'b1; bus.MEM_Req_i = 1'b1; bus.Branch_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_HOLD) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_now(), C_HOLD);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_HOLD) begin
            errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl_now(), C_HOLD);
        end
        checks++;
        if (bus.StallCnt_o !== 16'd0 || bus.FlushCnt_o !== 16'd0 || bus.Err_o !== 1'b0) begin
            errors++; $display("FAIL reset_counters: got %h/%h/%b expected 0000/0000/0",
                               bus.StallCnt_o, bus.FlushCnt_o, bus.Err_o);
        end
        tick();
    endtask

    task automatic test_start();
        clear_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        bus.start_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_HOLD) begin
            errors++; $display("FAIL start_cycle: got %b expected %b", ctrl_now(), C_HOLD);
        end
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl_now() !== C_FLOW) begin
                errors++; $display("FAIL run_flow_%0d: got %b expected %b", i, ctrl_now(), C_FLOW);
            end
            tick();
        end
        checks++;
        if (bus.StallCnt_o !== 16'd0) begin
            errors++; $display("FAIL start_stallcnt: got %0d expected 0", bus.StallCnt_o);
        end
    endtask

    task automatic test_loaduse();
        do_reset_and_start();
        set_load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_BUBBLE) begin
            errors++; $display("FAIL loaduse_rs2: got %b expected %b", ctrl_now(), C_BUBBLE);
        end
        tick();
        checks++;
        if (bus.StallCnt_o !== 16'd1) begin
            errors++; $display("FAIL loaduse_stallcnt: got %0d expected 1", bus.StallCnt_o);
        end
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW) begin
            errors++; $display("FAIL loaduse_x0: got %b expected %b", ctrl_now(), C_FLOW);
        end
        tick();
        set_load(5'd7, 5'd7, 1'b1, 5'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_BUBBLE) begin
            errors++; $display("FAIL loaduse_rs1: got %b expected %b", ctrl_now(), C_BUBBLE);
        end
        tick();
        set_load(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW) begin
            errors++; $display("FAIL loaduse_unused: got %b expected %b", ctrl_now(), C_FLOW);
        end
        tick();
        checks++;
        if (bus.StallCnt_o !== 16'd2) begin
            errors++; $display("FAIL loaduse_stallcnt2: got %0d expected 2", bus.StallCnt_o);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset_and_start();
        bus.MEM_Req_i = 1'b1;
        bus.MEM_Ack_i = 1'b0;
        bus.Branch_i  = 1'b1;
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctrl_now() !== C_FREEZE) begin
                errors++; $display("FAIL mem_freeze_%0d: got %b expected %b", i, ctrl_now(), C_FREEZE);
            end
            tick();
        end
        clear_inputs();
        bus.MEM_Req_i = 1'b1;
        bus.MEM_Ack_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW) begin
            errors++; $display("FAIL mem_ack_cycle: got %b expected %b", ctrl_now(), C_FLOW);
        end
        tick();
        bus.MEM_Req_i = 1'b0;
        bus.MEM_Ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW || bus.StallCnt_o !== 16'd3 || bus.Err_o !== 1'b0) begin
            errors++; $display("FAIL mem_back_to_run: got %b/%0d/%b expected %b/3/0",
                               ctrl_now(), bus.StallCnt_o, bus.Err_o, C_FLOW);
        end
        tick();
        // Ack in the request cycle: no wait state follows.
        bus.MEM_Req_i = 1'b1;
        bus.MEM_Ack_i = 1'b1;
        tick();
        bus.MEM_Req_i = 1'b0;
        bus.MEM_Ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW || bus.StallCnt_o !== 16'd3) begin
            errors++; $display("FAIL mem_same_cycle_ack: got %b/%0d expected %b/3",
                               ctrl_now(), bus.StallCnt_o, C_FLOW);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset_and_start();
        set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        bus.Branch_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_BUBBLE) begin
            errors++; $display("FAIL branch_vs_loaduse: got %b expected %b", ctrl_now(), C_BUBBLE);
        end
        tick();
        bus.EX_MemRead_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLUSH) begin
            errors++; $display("FAIL branch_flush: got %b expected %b", ctrl_now(), C_FLUSH);
        end
        tick();
        bus.Branch_i = 1'b0;
        checks++;
        if (bus.FlushCnt_o !== 16'd1) begin
            errors++; $display("FAIL flushcnt: got %0d expected 1", bus.FlushCnt_o);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset_and_start();
        bus.MEM_Req_i = 1'b1;
        bus.MEM_Ack_i = 1'b0;
        tick();
        bus.MEM_Req_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (ctrl_now() !== C_FREEZE) begin
                errors++; $display("FAIL timeout_freeze_%0d: got %b expected %b", k, ctrl_now(), C_FREEZE);
            end
            tick();
            checks++;
            if (bus.Err_o !== (k >= TIMEOUT)) begin
                errors++; $display("FAIL timeout_err_%0d: got %b expected %b", k, bus.Err_o, (k >= TIMEOUT));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_HOLD) begin
            errors++; $display("FAIL timeout_rst_ctrl: got %b expected %b", ctrl_now(), C_HOLD);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.Err_o !== 1'b0 || ctrl_now() !== C_HOLD) begin
            errors++; $display("FAIL timeout_after_rst: got %b/%b expected 0/%b", bus.Err_o, ctrl_now(), C_HOLD);
        end
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_now() !== C_FLOW) begin
            errors++; $display("FAIL abandoned_access: got %b expected %b", ctrl_now(), C_FLOW);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] exp_c;
        do_reset_and_start();
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bus.start_i      = ($urandom_range(0, 3) == 0);
            bus.RS1addr_i    = 5'($urandom_range(0, 3));
            bus.RS2addr_i    = 5'($urandom_range(0, 3));
            bus.UseRS1_i     = 1'($urandom_range(0, 1));
            bus.UseRS2_i     = 1'($urandom_range(0, 1));
            bus.EX_MemRead_i = 1'($urandom_range(0, 1));
            bus.EX_RDaddr_i  = 5'($urandom_range(0, 3));
            bus.Branch_i     = ($urandom_range(0, 3) == 0);
            bus.MEM_Req_i    = ($urandom_range(0, 3) == 0);
            bus.MEM_Ack_i    = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            exp_c = model_ctrl();
            checks++;
            if (ctrl_now() !== exp_c) begin
                errors++; $display("FAIL rand_ctrl_%0d: got %b expected %b", n, ctrl_now(), exp_c);
            end
            tick();
            checks++;
            if (bus.StallCnt_o !== 16'(m_stall) || bus.FlushCnt_o !== 16'(m_flush) || bus.Err_o !== m_err) begin
                errors++; $display("FAIL rand_state_%0d: got %0d/%0d/%b expected %0d/%0d/%b", n,
                                   bus.StallCnt_o, bus.FlushCnt_o, bus.Err_o, m_stall, m_flush, m_err);
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_stall_saturation();
        do_reset_and_start();
        set_load(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 65534; i++) tick();
        checks++;
        if (bus.StallCnt_o !== 16'hFFFE) begin
            errors++; $display("FAIL stall_preload: got %h expected fffe", bus.StallCnt_o);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.StallCnt_o !== 16'hFFFF || bus.FlushCnt_o !== 16'd0) begin
            errors++; $display("FAIL stall_saturate: got %h/%h expected ffff/0000", bus.StallCnt_o, bus.FlushCnt_o);
        end
        clear_inputs();
    endtask

    initial begin
        m_state = M_IDLE; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
        clear_inputs();
        #1;
        test_reset();
        test_start();
        test_loaduse();
        test_mem_wait();
        test_branch_priority();
        test_timeout();
        test_random();
        test_stall_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
